// File: rtl/ripple_count_ctrl.sv
// Single-clock sequencer for an asynchronous ripple up-counter: clears it, ticks it
// to a programmed target, and verifies each settled sample against a shadow count.
module ripple_count_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_tick,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_TICK  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  logic [2:0]       state, nstate;
  logic [3:0]       settle;
  logic [WIDTH-1:0] shadow, target_r;
  logic             accept, mismatch, at_target;

  // DONE accepts a new start directly so back-to-back runs lose no cycle.
  always_comb begin
    accept    = start & ~abort & ((state == S_IDLE) | (state == S_DONE));
    mismatch  = (cnt_q != shadow);
    at_target = (cnt_q == target_r);
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (accept) nstate = S_CLR;
      S_CLR:   nstate = S_WAIT;
      S_WAIT:  if (settle == '0) nstate = S_CHECK;
      S_CHECK: nstate = (mismatch | at_target) ? S_DONE : S_TICK;
      S_TICK:  nstate = S_WAIT;
      S_DONE:  nstate = accept ? S_CLR : S_IDLE;
      default: nstate = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nstate = S_IDLE;
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_tick <= 1'b0;
      cnt_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      shadow   <= '0;
      target_r <= '0;
      settle   <= '0;
    end else begin
      state    <= nstate;
      cnt_tick <= (nstate == S_TICK);
      cnt_rst  <= (nstate == S_CLR);
      busy     <= (nstate == S_CLR) | (nstate == S_WAIT) |
                  (nstate == S_CHECK) | (nstate == S_TICK);
      done     <= (nstate == S_DONE);

      if (nstate == S_WAIT && state != S_WAIT)
        settle <= SETTLE_LD;
      else if (state == S_WAIT && settle != '0)
        settle <= settle - 4'd1;

      if (accept) begin
        target_r <= target;
        err      <= 1'b0;
        shadow   <= '0;
      end

      // An abort during CHECK leaves err and count untouched.
      if (state == S_CHECK && !abort) begin
        count <= cnt_q;
        if (mismatch)
          err <= 1'b1;
        else if (!at_target)
          shadow <= shadow + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Directed bench for ripple_count_ctrl with a behavioural ripple counter that can
// have bits forced to zero to provoke shadow-count mismatches.
module tb_ripple_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] target = '0;
  logic [3:0] cnt_q;
  logic       cnt_tick, cnt_rst, busy, done, err;
  logic [3:0] count;

  logic [3:0] rc = '0;
  logic [3:0] stuck_mask = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge cnt_tick or posedge cnt_rst)
    if (cnt_rst) rc <= '0;
    else         rc <= rc + 4'd1;

  assign cnt_q = rc & ~stuck_mask;

  ripple_count_ctrl #(.WIDTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .cnt_q(cnt_q), .cnt_tick(cnt_tick), .cnt_rst(cnt_rst), .busy(busy),
    .done(done), .err(err), .count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] mask;
    bit         chain;
    int         ticks;
    int         done_cyc;
    logic [3:0] cnt;
    bit         err;
  } vec_t;

  vec_t vt[6];

  // Starts a run from the current point (just after a negedge) and follows it to done.
  task automatic run(input int idx);
    int n, ticks, done_at, overlap;
    logic busy_at_done;
    ticks = 0; done_at = -1; overlap = 0; busy_at_done = 1'b1;
    stuck_mask = vt[idx].mask;
    start = 1'b1;
    target = vt[idx].tgt;
    @(posedge clk);
    #1 start = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk($sformatf("v%0d clr_rst", idx), cnt_rst, 1);
        chk($sformatf("v%0d clr_busy", idx), busy, 1);
        chk($sformatf("v%0d clr_err", idx), err, 0);
      end
      if (cnt_tick) ticks++;
      if (cnt_tick && cnt_rst) overlap++;
      if (done) begin
        done_at = n;
        busy_at_done = busy;
        break;
      end
    end
    chk($sformatf("v%0d done_cycle", idx), done_at, vt[idx].done_cyc);
    chk($sformatf("v%0d ticks", idx), ticks, vt[idx].ticks);
    chk($sformatf("v%0d count", idx), count, vt[idx].cnt);
    chk($sformatf("v%0d err", idx), err, vt[idx].err);
    chk($sformatf("v%0d busy_in_done", idx), busy_at_done, 0);
    chk($sformatf("v%0d tick_rst_overlap", idx), overlap, 0);
  endtask

  initial begin
    int dones, busys;
    //          tgt    mask     chain ticks done cnt    err
    vt[0] = '{4'd3,  4'b0000, 1'b0, 3,  17, 4'd3,  1'b0};
    vt[1] = '{4'd0,  4'b0000, 1'b0, 0,  5,  4'd0,  1'b0};
    vt[2] = '{4'd15, 4'b0000, 1'b0, 15, 65, 4'd15, 1'b0};
    vt[3] = '{4'd2,  4'b0000, 1'b1, 2,  13, 4'd2,  1'b0};
    vt[4] = '{4'd5,  4'b0010, 1'b0, 2,  13, 4'd0,  1'b1};
    vt[5] = '{4'd1,  4'b0000, 1'b0, 1,  9,  4'd1,  1'b0};

    #12;
    chk("rst cnt_tick", cnt_tick, 0);
    chk("rst cnt_rst", cnt_rst, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst count", count, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle cnt_rst", cnt_rst, 0);

    for (int i = 0; i < 6; i++) begin
      if (!vt[i].chain) repeat (2) @(negedge clk);
      run(i);
    end

    // Abort in the second WAIT (cycle 6) with start asserted alongside.
    repeat (2) @(negedge clk);
    stuck_mask = '0;
    start = 1'b1; target = 4'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort busy", busy, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin abort = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort cnt_tick", cnt_tick, 0);
    chk("abort cnt_rst", cnt_rst, 0);
    chk("abort count", count, 0);
    dones = 0; busys = 0;
    repeat (10) begin
      if (done) dones++;
      if (busy) busys++;
      @(negedge clk);
    end
    chk("abort no_done", dones, 0);
    chk("abort stays_idle", busys, 0);

    // Asynchronous reset during the third TICK (cycle 13, count already 2).
    start = 1'b1; target = 4'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(negedge clk);
    chk("tick3 cnt_tick", cnt_tick, 1);
    chk("tick3 count", count, 2);
    #1 rst = 1'b1;
    #1;
    chk("arst cnt_tick", cnt_tick, 0);
    chk("arst cnt_rst", cnt_rst, 1);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst err", err, 0);
    chk("arst count", count, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
